me_pixel_fetch: RTL and testbench

- Data-side responder for the motion-estimation search controller.
- The controller drives four one-hot phase strobes: load_cpr, load_spr, sr_spr, sd_spr.
- This block turns each strobe into reads of the current-frame and reference-frame memories, returns the pixel words on cpr/spr, and maintains the progress counters the controller compares against its limits.
- It sits between the controller and the two frame RAMs (1-cycle read latency).

---
 rtl/me_pixel_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_me_pixel_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_pixel_fetch.sv
// Motion-estimation pixel fetch: turns controller phase strobes into frame-RAM
// reads, returns the pixel words and keeps the per-phase progress counters.
module me_pixel_fetch #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 16,
    parameter int SRR   = 15,
    parameter int SRD   = 17,
    parameter int AW    = 10,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_cpr,
    input  logic             load_spr,
    input  logic             sr_spr,
    input  logic             sd_spr,
    input  logic [AW-1:0]    cur_base,
    input  logic [AW-1:0]    ref_base,
    input  logic [AW-1:0]    ref_stride,
    output logic             cur_re,
    output logic [AW-1:0]    cur_addr,
    input  logic [WIDTH-1:0] cur_rdata,
    output logic             ref_re,
    output logic [AW-1:0]    ref_addr,
    input  logic [WIDTH-1:0] ref_rdata,
    output logic [WIDTH-1:0] cpr,
    output logic             cpr_valid,
    output logic [WIDTH-1:0] spr,
    output logic             spr_valid,
    output logic [1:0]       spr_kind,
    output logic [CW-1:0]    count_cpr,
    output logic [CW-1:0]    count_spr,
    output logic [CW-1:0]    count_srr,
    output logic [CW-1:0]    count_srd
);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_CPR,
        PH_SPR,
        PH_SR,
        PH_SD
    } phase_t;

    localparam logic [CW-1:0] LIM_CPR = CW'(SIZE);
    localparam logic [CW-1:0] LIM_SPR = CW'(SIZE);
    localparam logic [CW-1:0] LIM_SR  = CW'(SRR);
    localparam logic [CW-1:0] LIM_SD  = CW'(SRD);

    phase_t          phase;
    phase_t          prev_phase;
    phase_t          pend_phase;
    logic            pend_valid;
    logic            start;
    logic            issue;
    logic [CW-1:0]   issue_cnt;
    logic [CW-1:0]   r_eff;
    logic [CW-1:0]   limit;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_eff;
    logic [AW-1:0]   cur_base_q;
    logic [AW-1:0]   ref_base_q;
    logic [AW-1:0]   cur_b;
    logic [AW-1:0]   ref_b;
    logic [AW-1:0]   sd_off;
    logic            ret_cpr;
    logic            ret_spr;
    logic            ret_sr;
    logic            ret_sd;

    // Phase register: remembers which phase was active last cycle so a new
    // or re-asserted strobe is recognised as a phase start.
    // NOTE: reset is synchronous and active-low, so it only appears inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_phase <= PH_IDLE;
        end else begin
            prev_phase <= phase;
        end
    end

    // Next-phase selection: fixed priority across the one-hot strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        phase = PH_IDLE;
        if (load_cpr)      phase = PH_CPR;
        else if (load_spr) phase = PH_SPR;
        else if (sr_spr)   phase = PH_SR;
        else if (sd_spr)   phase = PH_SD;
    end

    // SIZE is a constant, so this is a fixed shift-add, not a general multiplier.
    assign sd_off = AW'(SIZE) * ref_stride;

    // Issue logic: on a phase start the counters and bases are used as if
    // already cleared/latched, so the first read goes out that same cycle.
    always_comb begin
        start   = (phase != PH_IDLE) && (phase != prev_phase);
        r_eff   = start ? '0 : issue_cnt;
        acc_eff = start ? '0 : acc_q;
        cur_b   = start ? cur_base : cur_base_q;
        ref_b   = start ? ref_base : ref_base_q;
        case (phase)
            PH_CPR:  limit = LIM_CPR;
            PH_SPR:  limit = LIM_SPR;
            PH_SR:   limit = LIM_SR;
            PH_SD:   limit = LIM_SD;
            default: limit = '0;
        endcase
        issue    = reset && (phase != PH_IDLE) && (r_eff < limit);
        cur_re   = 1'b0;
        cur_addr = '0;
        ref_re   = 1'b0;
        ref_addr = '0;
        if (issue) begin
            case (phase)
                PH_CPR: begin
                    cur_re   = 1'b1;
                    cur_addr = cur_b + AW'(r_eff);
                end
                PH_SPR: begin
                    ref_re   = 1'b1;
                    ref_addr = ref_b + acc_eff;
                end
                PH_SR: begin
                    ref_re   = 1'b1;
                    ref_addr = ref_b + AW'(1) + AW'(r_eff);
                end
                PH_SD: begin
                    ref_re   = 1'b1;
                    ref_addr = ref_b + sd_off + acc_eff;
                end
                default: ;
            endcase
        end
    end

    // Issue bookkeeping; acc_q tracks r*ref_stride without a multiplier.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt  <= '0;
            acc_q      <= '0;
            cur_base_q <= '0;
            ref_base_q <= '0;
            pend_valid <= 1'b0;
            pend_phase <= PH_IDLE;
        end else begin
            if (start) begin
                cur_base_q <= cur_base;
                ref_base_q <= ref_base;
            end
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            issue_cnt  <= issue ? r_eff + CW'(1) : r_eff;
            acc_q      <= issue ? acc_eff + ref_stride : acc_eff;
            pend_valid <= issue;
            pend_phase <= issue ? phase : PH_IDLE;
        end
    end

    assign ret_cpr = pend_valid && (pend_phase == PH_CPR);
    assign ret_spr = pend_valid && (pend_phase == PH_SPR);
    assign ret_sr  = pend_valid && (pend_phase == PH_SR);
    assign ret_sd  = pend_valid && (pend_phase == PH_SD);

    // Return path: the read issued last cycle lands on cpr/spr now, even if
    // its phase has since ended.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpr       <= '0;
            cpr_valid <= 1'b0;
            spr       <= '0;
            spr_valid <= 1'b0;
            spr_kind  <= 2'd0;
        end else begin
            cpr_valid <= ret_cpr;
            spr_valid <= ret_spr || ret_sr || ret_sd;
            if (ret_cpr) cpr <= cur_rdata;
            if (ret_spr || ret_sr || ret_sd) spr <= ref_rdata;
            if (ret_spr)     spr_kind <= 2'd0;
            else if (ret_sr) spr_kind <= 2'd1;
            else if (ret_sd) spr_kind <= 2'd2;
        end
    end

    // Returned counters: cleared on their own phase start, saturate at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_cpr <= '0;
            count_spr <= '0;
            count_srr <= '0;
            count_srd <= '0;
        end else begin
            if (start && phase == PH_CPR)        count_cpr <= '0;
            else if (ret_cpr && count_cpr < LIM_CPR) count_cpr <= count_cpr + CW'(1);

            if (start && phase == PH_SPR)        count_spr <= '0;
            else if (ret_spr && count_spr < LIM_SPR) count_spr <= count_spr + CW'(1);

            if (start && phase == PH_SR)         count_srr <= '0;
            else if (ret_sr && count_srr < LIM_SR)   count_srr <= count_srr + CW'(1);

            if (start && phase == PH_SD)         count_srd <= '0;
            else if (ret_sd && count_srd < LIM_SD)   count_srd <= count_srd + CW'(1);
        end
    end

endmodule

// File: tb/tb_me_pixel_fetch.sv
// Directed bench for me_pixel_fetch: behavioural 1-cycle RAMs, hand-derived
// addresses, data, valids and counters for each controller phase.
module tb_me_pixel_fetch;

    logic        clk;
    logic        reset;
    logic        load_cpr, load_spr, sr_spr, sd_spr;
    logic [9:0]  cur_base, ref_base, ref_stride;
    logic        cur_re, ref_re;
    logic [9:0]  cur_addr, ref_addr;
    logic [15:0] cur_rdata, ref_rdata;
    logic [15:0] cpr, spr;
    logic        cpr_valid, spr_valid;
    logic [1:0]  spr_kind;
    logic [4:0]  count_cpr, count_spr, count_srr, count_srd;

    int vectors;
    int miscompares;

    me_pixel_fetch dut (
        .clk(clk), .reset(reset),
        .load_cpr(load_cpr), .load_spr(load_spr), .sr_spr(sr_spr), .sd_spr(sd_spr),
        .cur_base(cur_base), .ref_base(ref_base), .ref_stride(ref_stride),
        .cur_re(cur_re), .cur_addr(cur_addr), .cur_rdata(cur_rdata),
        .ref_re(ref_re), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
        .cpr(cpr), .cpr_valid(cpr_valid), .spr(spr), .spr_valid(spr_valid),
        .spr_kind(spr_kind),
        .count_cpr(count_cpr), .count_spr(count_spr),
        .count_srr(count_srr), .count_srd(count_srd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cdat(input logic [9:0] a);
        return 16'hC000 | {6'd0, a};
    endfunction

    function automatic logic [15:0] rdat(input logic [9:0] a);
        return 16'h5000 ^ {6'd0, a};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Frame RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (cur_re) cur_rdata <= cdat(cur_addr);
        if (ref_re) ref_rdata <= rdat(ref_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a;
        vectors     = 0;
        miscompares = 0;
        reset      = 1'b0;
        load_cpr   = 1'b0;
        load_spr   = 1'b0;
        sr_spr     = 1'b0;
        sd_spr     = 1'b0;
        cur_base   = '0;
        ref_base   = '0;
        ref_stride = '0;
        cur_rdata  = '0;
        ref_rdata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst cur_re", cur_re, 0);
        check("rst ref_re", ref_re, 0);
        check("rst cur_addr", cur_addr, 0);
        check("rst ref_addr", ref_addr, 0);
        check("rst cpr", cpr, 0);
        check("rst cpr_valid", cpr_valid, 0);
        check("rst spr", spr, 0);
        check("rst spr_valid", spr_valid, 0);
        check("rst spr_kind", spr_kind, 0);
        check("rst count_cpr", count_cpr, 0);
        check("rst count_spr", count_spr, 0);
        check("rst count_srr", count_srr, 0);
        check("rst count_srd", count_srd, 0);

        // CPR block load, strobe held past the limit
        @(negedge clk);
        reset    = 1'b1;
        load_cpr = 1'b1;
        cur_base = 10'h040;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("cpr cur_re[%0d]", i), cur_re, (i < 16) ? 1 : 0);
            check($sformatf("cpr cur_addr[%0d]", i), cur_addr, (i < 16) ? 32'h40 + i : 0);
            check($sformatf("cpr ref_re[%0d]", i), ref_re, 0);
            check($sformatf("cpr cpr_valid[%0d]", i), cpr_valid, (i >= 2 && i <= 17) ? 1 : 0);
            if (i >= 2 && i <= 17) check($sformatf("cpr data[%0d]", i), cpr, cdat(10'(32'h40 + i - 2)));
            if (i >= 1) check($sformatf("cpr count[%0d]", i), count_cpr, sat(i - 1, 16));
            @(negedge clk);
        end
        check("cpr hold data", cpr, cdat(10'h04F));
        load_cpr = 1'b0;

        // SPR block load
        @(negedge clk);
        load_spr   = 1'b1;
        ref_base   = 10'h100;
        ref_stride = 10'h020;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("spr ref_re[%0d]", i), ref_re, (i < 16) ? 1 : 0);
            check($sformatf("spr ref_addr[%0d]", i), ref_addr, (i < 16) ? 32'h100 + 32'h20 * i : 0);
            check($sformatf("spr valid[%0d]", i), spr_valid, (i >= 2 && i <= 17) ? 1 : 0);
            if (i >= 2 && i <= 17) begin
                check($sformatf("spr data[%0d]", i), spr, rdat(10'(32'h100 + 32'h20 * (i - 2))));
                check($sformatf("spr kind[%0d]", i), spr_kind, 0);
            end
            if (i >= 1) check($sformatf("spr count[%0d]", i), count_spr, sat(i - 1, 16));
            @(negedge clk);
        end
        load_spr = 1'b0;

        // Shift right, then shift down
        @(negedge clk);
        sr_spr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            check($sformatf("sr ref_re[%0d]", i), ref_re, (i < 15) ? 1 : 0);
            check($sformatf("sr ref_addr[%0d]", i), ref_addr, (i < 15) ? 32'h101 + i : 0);
            check($sformatf("sr valid[%0d]", i), spr_valid, (i >= 2 && i <= 16) ? 1 : 0);
            if (i >= 2 && i <= 16) begin
                check($sformatf("sr data[%0d]", i), spr, rdat(10'(32'h101 + i - 2)));
                check($sformatf("sr kind[%0d]", i), spr_kind, 1);
            end
            if (i >= 1) check($sformatf("sr count[%0d]", i), count_srr, sat(i - 1, 15));
            @(negedge clk);
        end
        sr_spr = 1'b0;
        sd_spr = 1'b1;
        for (int j = 0; j < 20; j++) begin
            #1;
            a = 10'(32'h300 + 32'h20 * j);
            check($sformatf("sd ref_re[%0d]", j), ref_re, (j < 17) ? 1 : 0);
            check($sformatf("sd ref_addr[%0d]", j), ref_addr, (j < 17) ? a : 0);
            check($sformatf("sd valid[%0d]", j), spr_valid, (j >= 2 && j <= 18) ? 1 : 0);
            if (j >= 2 && j <= 18) begin
                check($sformatf("sd data[%0d]", j), spr, rdat(10'(32'h300 + 32'h20 * (j - 2))));
                check($sformatf("sd kind[%0d]", j), spr_kind, 2);
            end
            if (j >= 1) check($sformatf("sd count[%0d]", j), count_srd, sat(j - 1, 17));
            @(negedge clk);
        end
        sd_spr = 1'b0;
        check("srr count held", count_srr, 15);

        // Priority: load_cpr wins over sr_spr
        @(negedge clk);
        load_cpr = 1'b1;
        sr_spr   = 1'b1;
        cur_base = 10'h200;
        for (int i = 0; i < 18; i++) begin
            #1;
            check($sformatf("prio cur_re[%0d]", i), cur_re, (i < 16) ? 1 : 0);
            check($sformatf("prio cur_addr[%0d]", i), cur_addr, (i < 16) ? 32'h200 + i : 0);
            check($sformatf("prio ref_re[%0d]", i), ref_re, 0);
            check($sformatf("prio spr_valid[%0d]", i), spr_valid, 0);
            @(negedge clk);
        end
        check("prio count_cpr", count_cpr, 16);
        check("prio count_srr", count_srr, 15);
        load_cpr = 1'b0;
        sr_spr   = 1'b0;

        // Reset mid-phase with a read in flight
        @(negedge clk);
        load_spr = 1'b1;
        ref_base = 10'h100;
        for (int i = 0; i < 8; i++) @(negedge clk);
        #1;
        check("rstmid count_spr before", count_spr, 7);
        check("rstmid ref_re before", ref_re, 1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid ref_re", ref_re, 0);
        check("rstmid ref_addr", ref_addr, 0);
        check("rstmid spr_valid", spr_valid, 0);
        check("rstmid spr", spr, 0);
        check("rstmid count_spr", count_spr, 0);
        check("rstmid count_cpr", count_cpr, 0);
        check("rstmid cpr", cpr, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart ref_re", ref_re, 1);
        check("restart ref_addr", ref_addr, 10'h100);
        @(negedge clk);
        #1;
        check("restart spr_valid c1", spr_valid, 0);
        check("restart count c1", count_spr, 0);
        check("restart ref_addr c1", ref_addr, 10'h120);
        @(negedge clk);
        #1;
        check("restart spr_valid c2", spr_valid, 1);
        check("restart spr c2", spr, rdat(10'h100));
        check("restart count c2", count_spr, 1);
        load_spr = 1'b0;
        repeat (3) @(negedge clk);

        // Strobe dropped after three issues
        load_spr = 1'b1;
        ref_base = 10'h180;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) load_spr = 1'b0;
            #1;
            check($sformatf("drop ref_re[%0d]", i), ref_re, (i < 3) ? 1 : 0);
            check($sformatf("drop valid[%0d]", i), spr_valid, (i >= 2 && i <= 4) ? 1 : 0);
            if (i >= 2 && i <= 4) check($sformatf("drop data[%0d]", i), spr, rdat(10'(32'h180 + 32'h20 * (i - 2))));
            if (i >= 1) check($sformatf("drop count[%0d]", i), count_spr, sat(i - 1, 3));
            @(negedge clk);
        end
        check("drop spr hold", spr, rdat(10'h1C0));

        // Address wrap modulo 2^AW
        load_spr = 1'b1;
        ref_base = 10'h3F0;
        #1;
        check("wrap addr0", ref_addr, 10'h3F0);
        @(negedge clk);
        #1;
        check("wrap addr1", ref_addr, 10'h010);
        @(negedge clk);
        #1;
        check("wrap addr2", ref_addr, 10'h030);
        check("wrap data0", spr, rdat(10'h3F0));
        @(negedge clk);
        #1;
        check("wrap data1", spr, rdat(10'h010));
        load_spr = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
